// File: rtl/osc_mix_scheduler.sv
// osc_mix_scheduler
// Sample-rate scheduler and mixer for the oscillator bank.
// A fractional accumulator derives a sample tick from the system clock. On each
// tick the enabled channels are polled one at a time over ready/valid. Each
// sample is scaled by its unsigned Q0.8 gain through one shared multiplier and
// added into a saturating sum. The mixed sample is then offered on a
// ready/valid output.
//
// Ports
//   clk_i        system clock
//   reset_ni     synchronous active-low reset
//   en_i         per-channel enable, latched at the tick
//   gain_i       per-channel Q0.8 gain, channel k at [8k+7:8k], latched at the tick
//   osc_data_i   oscillator samples, channel k at [width_p*k +: width_p]
//   osc_valid_i  oscillator sample valid
//   osc_ready_o  one-hot request to the channel being polled
//   data_o       mixed, saturated sample
//   valid_o      data_o valid
//   ready_i      sink accepts data_o
//   busy_o       scheduler is not idle
//   overrun_o    one-cycle pulse: a tick arrived while busy and was dropped
//   timeout_o    one-cycle pulse: a channel poll was abandoned
module osc_mix_scheduler #(
  parameter int width_p       = 16,
  parameter int num_ch_p      = 4,
  parameter int clk_freq_p    = 17000000,
  parameter int sample_rate_p = 44100,
  parameter int timeout_p     = 16
) (
  input  logic                          clk_i,
  input  logic                          reset_ni,
  input  logic [num_ch_p-1:0]           en_i,
  input  logic [8*num_ch_p-1:0]         gain_i,
  input  logic [width_p*num_ch_p-1:0]   osc_data_i,
  input  logic [num_ch_p-1:0]           osc_valid_i,
  output logic [num_ch_p-1:0]           osc_ready_o,
  output logic [width_p-1:0]            data_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic                          busy_o,
  output logic                          overrun_o,
  output logic                          timeout_o
);

  localparam int acc_w_lp  = $clog2(clk_freq_p + sample_rate_p);
  localparam int ch_w_lp   = (num_ch_p > 1) ? $clog2(num_ch_p) : 1;
  localparam int tmr_w_lp  = $clog2(timeout_p + 1);
  localparam int sum_w_lp  = width_p + 4;
  localparam int prod_w_lp = width_p + 9;

  localparam logic [acc_w_lp-1:0] rate_lp     = acc_w_lp'(sample_rate_p);
  localparam logic [acc_w_lp-1:0] clk_lp      = acc_w_lp'(clk_freq_p);
  localparam logic [tmr_w_lp-1:0] tmr_last_lp = tmr_w_lp'(timeout_p - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_MUL  = 3'd2,
    ST_ACC  = 3'd3,
    ST_NEXT = 3'd4,
    ST_OUT  = 3'd5
  } state_t;

  // Lowest enabled channel with index >= start; MSB of the result is "found".
  function automatic logic [ch_w_lp:0] find_ch(input logic [num_ch_p-1:0] en,
                                                input int start);
    logic                found;
    logic [ch_w_lp-1:0]  idx;
    found = 1'b0;
    idx   = {ch_w_lp{1'b0}};
    // Scan downward so the lowest qualifying channel is the last one written.
    for (int i = num_ch_p - 1; i >= 0; i--) begin
      found = (en[i] && (i >= start)) ? 1'b1 : found;
      idx   = (en[i] && (i >= start)) ? ch_w_lp'(i) : idx;
    end
    return {found, idx};
  endfunction

  // Clamp the wide accumulator to the signed output range.
  function automatic logic [width_p-1:0] sat(input logic [sum_w_lp-1:0] s);
    logic [width_p-1:0] r;
    if ($signed(s) > $signed({{5{1'b0}}, {(width_p-1){1'b1}}})) begin
      r = {1'b0, {(width_p-1){1'b1}}};
    end else if ($signed(s) < $signed({{5{1'b1}}, {(width_p-1){1'b0}}})) begin
      r = {1'b1, {(width_p-1){1'b0}}};
    end else begin
      r = s[width_p-1:0];
    end
    return r;
  endfunction

  state_t                   state_r, state_s;
  logic [acc_w_lp-1:0]      acc_r, acc_s, acc_sum_s;
  logic                     tick_s;
  logic [num_ch_p-1:0]      en_r, en_s;
  logic [8*num_ch_p-1:0]    gain_r, gain_s;
  logic [ch_w_lp-1:0]       k_r, k_s;
  logic [ch_w_lp:0]         find_s;
  logic [tmr_w_lp-1:0]      tmr_r, tmr_s;
  logic [width_p-1:0]       cap_r, cap_s;
  logic [prod_w_lp-1:0]     prod_full_s;
  logic signed [prod_w_lp-1:0] prod_r, prod_s;
  logic [sum_w_lp-1:0]      sum_r, sum_s;
  logic                     timeout_s, overrun_s;
  logic [num_ch_p-1:0]      ready_s;
  logic [width_p-1:0]       data_s;
  logic                     valid_s, busy_s;

  logic [num_ch_p-1:0]      osc_ready_r;
  logic [width_p-1:0]       data_r;
  logic                     valid_r, busy_r, overrun_r, timeout_r;

  // Fractional tick generator: accumulate the sample rate, wrap at the clock rate.
  always_comb begin
    acc_sum_s = acc_r + rate_lp;
    tick_s    = 1'b0;
    acc_s     = acc_sum_s;
    if (acc_sum_s >= clk_lp) begin
      tick_s = 1'b1;
      acc_s  = acc_sum_s - clk_lp;
    end else begin
      tick_s = 1'b0;
      acc_s  = acc_sum_s;
    end
  end

  // Scheduler next-state and datapath.
  always_comb begin
    state_s     = state_r;
    en_s        = en_r;
    gain_s      = gain_r;
    k_s         = k_r;
    tmr_s       = tmr_r;
    cap_s       = cap_r;
    prod_s      = prod_r;
    sum_s       = sum_r;
    timeout_s   = 1'b0;
    find_s      = {(ch_w_lp+1){1'b0}};
    prod_full_s = {prod_w_lp{1'b0}};
    // A tick that finds us busy (including the OUT->IDLE cycle) is dropped.
    overrun_s   = tick_s && (state_r != ST_IDLE);
    case (state_r)
      ST_IDLE: begin
        if (tick_s) begin
          en_s   = en_i;
          gain_s = gain_i;
          sum_s  = {sum_w_lp{1'b0}};
          find_s = find_ch(en_i, 0);
          if (find_s[ch_w_lp]) begin
            k_s     = find_s[ch_w_lp-1:0];
            tmr_s   = {tmr_w_lp{1'b0}};
            state_s = ST_REQ;
          end else begin
            k_s     = {ch_w_lp{1'b0}};
            state_s = ST_OUT;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (osc_valid_i[k_r]) begin
          cap_s   = osc_data_i[int'(k_r)*width_p +: width_p];
          state_s = ST_MUL;
        end else if (tmr_r == tmr_last_lp) begin
          timeout_s = 1'b1;
          state_s   = ST_NEXT;
        end else begin
          tmr_s = tmr_r + tmr_w_lp'(1);
        end
      end
      ST_MUL: begin
        // Low prod_w bits of the product are the same for signed and unsigned
        // operands, so sign-extend the sample and zero-extend the gain.
        prod_full_s = {{9{cap_r[width_p-1]}}, cap_r}
                    * {{(width_p+1){1'b0}}, gain_r[{k_r, 3'b000} +: 8]};
        prod_s      = $signed(prod_full_s) >>> 4'd8;
        state_s     = ST_ACC;
      end
      ST_ACC: begin
        // The shifted product always fits in sum_w bits.
        sum_s   = sum_r + prod_r[sum_w_lp-1:0];
        state_s = ST_NEXT;
      end
      ST_NEXT: begin
        find_s = find_ch(en_r, int'(k_r) + 1);
        if (find_s[ch_w_lp]) begin
          k_s     = find_s[ch_w_lp-1:0];
          tmr_s   = {tmr_w_lp{1'b0}};
          state_s = ST_REQ;
        end else begin
          state_s = ST_OUT;
        end
      end
      ST_OUT: begin
        if (ready_i) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_OUT;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Output values derived from the next state so the registered outputs line up with it.
  always_comb begin
    ready_s = {num_ch_p{1'b0}};
    data_s  = {width_p{1'b0}};
    valid_s = 1'b0;
    busy_s  = (state_s != ST_IDLE);
    if (state_s == ST_REQ) begin
      ready_s = num_ch_p'(1'b1) << k_s;
    end else begin
      ready_s = {num_ch_p{1'b0}};
    end
    if (state_s == ST_OUT) begin
      data_s  = sat(sum_s);
      valid_s = 1'b1;
    end else begin
      data_s  = {width_p{1'b0}};
      valid_s = 1'b0;
    end
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_r     <= ST_IDLE;
      acc_r       <= {acc_w_lp{1'b0}};
      en_r        <= {num_ch_p{1'b0}};
      gain_r      <= {(8*num_ch_p){1'b0}};
      k_r         <= {ch_w_lp{1'b0}};
      tmr_r       <= {tmr_w_lp{1'b0}};
      cap_r       <= {width_p{1'b0}};
      prod_r      <= {prod_w_lp{1'b0}};
      sum_r       <= {sum_w_lp{1'b0}};
      osc_ready_r <= {num_ch_p{1'b0}};
      data_r      <= {width_p{1'b0}};
      valid_r     <= 1'b0;
      busy_r      <= 1'b0;
      overrun_r   <= 1'b0;
      timeout_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      acc_r       <= acc_s;
      en_r        <= en_s;
      gain_r      <= gain_s;
      k_r         <= k_s;
      tmr_r       <= tmr_s;
      cap_r       <= cap_s;
      prod_r      <= prod_s;
      sum_r       <= sum_s;
      osc_ready_r <= ready_s;
      data_r      <= data_s;
      valid_r     <= valid_s;
      busy_r      <= busy_s;
      overrun_r   <= overrun_s;
      timeout_r   <= timeout_s;
    end
  end

  assign osc_ready_o = osc_ready_r;
  assign data_o      = data_r;
  assign valid_o     = valid_r;
  assign busy_o      = busy_r;
  assign overrun_o   = overrun_r;
  assign timeout_o   = timeout_r;

endmodule
